tb_ctrl_periph: RTL and testbench
=================================

// Module: tb_ctrl_periph
// PURPOSE
//  Memory-mapped slave on the core data bus that turns core stores into the
//  testbench end-of-test signals: tests_passed_o, tests_failed_o, exit_valid_o
//  and exit_value_o. It also buffers stdout characters in a FIFO and drains
//  them on a ready/valid stream. It sits in the wrapper beside the RAM and
//  feeds the testbench top that watches the exit signals.
// PARAMETERS
//  BASE_ADDR   32'h1000_0000  base of the 32-byte window; decode uses addr[31:5]
//  FIFO_DEPTH  16             stdout FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   reset, asynchronous, active-low
//  data_req_i     in   1   bus request, qualified by window decode
//  data_gnt_o     out  1   grant (combinational)
//  data_addr_i    in   32  byte address
//  data_we_i      in   1   1=write, 0=read
//  data_be_i      in   4   byte enables
//  data_wdata_i   in   32  write data
//  data_rvalid_o  out  1   response valid, one cycle after grant
//  data_rdata_o   out  32  read data, valid with rvalid
//  char_valid_o   out  1   stdout byte available
//  char_data_o    out  8   stdout byte (FIFO head)
//  char_ready_i   in   1   consumer accepts byte
//  tests_passed_o out  1   sticky pass flag
//  tests_failed_o out  1   sticky fail flag
//  exit_valid_o   out  1   sticky exit flag
//  exit_value_o   out  32  latched exit code
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   0x00 STDOUT W: push wdata[7:0] if be[0]; reads return 0
//   0x04 EXIT   W: exit_value_o<=wdata, exit_valid_o<=1
//   0x08 RESULT W: 32'd123456789 sets passed, 32'd1 sets failed, other values ignored
//   0x0C CYCLE  R: free-running 32-bit cycle count, wraps; W: clears to 0
//   0x10 STATUS R: {23'b0, full, level[7:0]}; level saturates at 255
//  Other offsets in the window: grant, rvalid, rdata=0, no side effect.
//  Handshake:
//   - gnt = req & hit & ~stall, where stall is:
//     (STDOUT write & FIFO full) | ((EXIT|RESULT) write & FIFO not empty).
//   - Exit and result writes therefore wait until every queued byte has drained.
//   - rvalid rises exactly one cycle after each grant, including writes.
//   - rdata is sampled at grant; it is 0 whenever rvalid=0.
//   - Side effects apply on the grant edge, so they are visible on the next cycle.
//  Flags: passed, failed and exit_valid are set-only until reset. Writing both
//   pass and exit in sequence leaves both set. A re-write of EXIT updates
//   exit_value_o.
//  FIFO:
//   - Push on granted STDOUT write with be[0]; pop on char_valid_o & char_ready_i.
//   - There is no bypass: a push into an empty FIFO gives char_valid_o the next cycle.
//   - Simultaneous push and pop leaves the level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Reset (async): all outputs 0, FIFO emptied, cycle count 0. Mid-operation reset
//   discards queued bytes, and no rvalid is issued for a grant cut short by reset.
// TESTING
//  - Write 0x48 then 0x69 to 0x00 with char_ready=1 -> stream 0x48,0x69 in order;
//    rvalid is seen one cycle after each gnt.
//  - char_ready=0, 16 STDOUT writes, then a 17th -> gnt low, STATUS reads 0x110;
//    one pop -> the 17th write is granted the next cycle.
//  - 3 bytes queued, char_ready=0, write 0 to EXIT -> gnt held low;
//    once all 3 are drained -> gnt; exit_valid_o=1 and exit_value_o=0 the next cycle.
//  - RESULT writes: 5 -> no flag; 123456789 -> tests_passed_o=1;
//    1 -> tests_failed_o=1; passed stays 1.
//  - Read CYCLE twice, 10 cycles apart -> difference 10;
//    write CYCLE, then read immediately -> value 1.
//  - Assert rst_n=0 with 4 bytes queued and exit_valid=1 -> all outputs 0 at once;
//    after release -> char_valid_o=0 and STATUS=0.

Source files
------------

// File: rtl/tb_ctrl_periph.sv
// Memory-mapped end-of-test peripheral: decodes a 32-byte window on the core data bus,
// latches pass/fail/exit status and queues stdout bytes onto a ready/valid stream.
module tb_ctrl_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [2:0]    OFF_STDOUT = 3'd0;
    localparam logic [2:0]    OFF_EXIT   = 3'd1;
    localparam logic [2:0]    OFF_RESULT = 3'd2;
    localparam logic [2:0]    OFF_CYCLE  = 3'd3;
    localparam logic [2:0]    OFF_STATUS = 3'd4;
    localparam logic [31:0]   PASS_CODE  = 32'd123456789;
    localparam logic [31:0]   FAIL_CODE  = 32'd1;
    localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

    function automatic logic [7:0] sat_level(input logic [CW-1:0] cnt);
        logic [31:0] wide;
        wide = 32'(cnt);
        if (wide > 32'd255) begin
            sat_level = 8'hFF;
        end else begin
            sat_level = wide[7:0];
        end
    endfunction

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   cycle_r;
    logic          rvalid_r;
    logic [31:0]   rdata_r;
    logic          passed_r, failed_r, exit_valid_r;
    logic [31:0]   exit_value_r;

    logic          hit_s, empty_s, full_s, stall_s, gnt_s, push_s, pop_s;
    logic          wr_stdout_s, wr_exit_s, wr_result_s, wr_cycle_s;
    logic [2:0]    sel_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    assign unused_s = ^{data_be_i[3:1], data_addr_i[1:0]};

    // Window decode, back-pressure and FIFO handshake terms
    always_comb begin
        sel_s       = data_addr_i[4:2];
        hit_s       = data_req_i && (data_addr_i[31:5] == BASE_ADDR[31:5]);
        empty_s     = (count_r == CNT_ZERO);
        full_s      = (count_r == CNT_FULL);
        wr_stdout_s = data_we_i && (sel_s == OFF_STDOUT);
        wr_exit_s   = data_we_i && (sel_s == OFF_EXIT);
        wr_result_s = data_we_i && (sel_s == OFF_RESULT);
        wr_cycle_s  = data_we_i && (sel_s == OFF_CYCLE);
        // Exit/result must not overtake queued stdout text
        stall_s     = (wr_stdout_s && full_s) || ((wr_exit_s || wr_result_s) && !empty_s);
        gnt_s       = hit_s && !stall_s;
        push_s      = gnt_s && wr_stdout_s && data_be_i[0];
        pop_s       = !empty_s && char_ready_i;
    end

    // Read data mux; CYCLE returns the count as it stands after the grant edge
    always_comb begin
        rdata_s = 32'd0;
        if (!data_we_i) begin
            case (sel_s)
                OFF_CYCLE:  rdata_s = cycle_r + 32'd1;
                OFF_STATUS: rdata_s = {23'd0, full_s, sat_level(count_r)};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Bus response: one-cycle rvalid after every grant, rdata zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
        end else begin
            rvalid_r <= gnt_s;
            rdata_r  <= gnt_s ? rdata_s : 32'd0;
        end
    end

    // Free-running cycle counter, cleared by a CYCLE write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_r <= 32'd0;
        end else if (gnt_s && wr_cycle_s) begin
            cycle_r <= 32'd0;
        end else begin
            cycle_r <= cycle_r + 32'd1;
        end
    end

    // Sticky end-of-test flags and exit code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            passed_r     <= 1'b0;
            failed_r     <= 1'b0;
            exit_valid_r <= 1'b0;
            exit_value_r <= 32'd0;
        end else begin
            if (gnt_s && wr_result_s && (data_wdata_i == PASS_CODE)) passed_r <= 1'b1;
            if (gnt_s && wr_result_s && (data_wdata_i == FAIL_CODE)) failed_r <= 1'b1;
            if (gnt_s && wr_exit_s) begin
                exit_valid_r <= 1'b1;
                exit_value_r <= data_wdata_i;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= data_wdata_i[7:0];
    end

    assign data_gnt_o     = gnt_s;
    assign data_rvalid_o  = rvalid_r;
    assign data_rdata_o   = rdata_r;
    assign char_valid_o   = !empty_s;
    assign char_data_o    = empty_s ? 8'h00 : mem_r[rd_ptr_r];
    assign tests_passed_o = passed_r;
    assign tests_failed_o = failed_r;
    assign exit_valid_o   = exit_valid_r;
    assign exit_value_o   = exit_value_r;
endmodule

// File: tb/tb_tb_ctrl_periph.sv
// Directed self-checking bench for tb_ctrl_periph: stdout stream, back-pressure,
// exit/result flags, cycle counter and asynchronous reset.
module tb_tb_ctrl_periph;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        char_valid_o;
    logic [7:0]  char_data_o;
    logic        char_ready_i;
    logic        tests_passed_o;
    logic        tests_failed_o;
    logic        exit_valid_o;
    logic [31:0] exit_value_o;

    int checks = 0;
    int fails  = 0;
    logic [7:0] rx_q[$];

    tb_ctrl_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .char_valid_o(char_valid_o), .char_data_o(char_data_o), .char_ready_i(char_ready_i),
        .tests_passed_o(tests_passed_o), .tests_failed_o(tests_failed_o),
        .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
    );

    always #5 clk = ~clk;

    // Collect stream bytes; inputs only change just after posedge, so negedge sees the accepted byte
    always @(negedge clk) begin
        if (char_valid_o && char_ready_i) rx_q.push_back(char_data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input string tag, input logic we, input logic [4:0] off,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        int n;
        @(posedge clk); #1;
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = BASE | {27'd0, off};
        data_wdata_i = wdata;
        data_be_i    = 4'hF;
        n = 0;
        @(negedge clk);
        while (data_gnt_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (data_gnt_o !== 1'b1) begin
            check({tag, "_gnt_timeout"}, {31'd0, data_gnt_o}, 32'd1);
            data_req_i = 1'b0;
            rdata = 32'd0;
        end else begin
            @(posedge clk); #1;
            data_req_i = 1'b0;
            @(negedge clk);
            check({tag, "_rvalid"}, {31'd0, data_rvalid_o}, 32'd1);
            rdata = data_rdata_o;
        end
    endtask

    initial begin
        logic [31:0] rd, c0, c1;
        int n;
        rst_n = 1'b0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = 32'd0;
        data_be_i = 4'h0; data_wdata_i = 32'd0; char_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {char_valid_o, tests_passed_o, tests_failed_o, exit_valid_o,
                              data_rvalid_o, data_gnt_o, 26'd0}, 32'd0);
        check("rst_exit_value", exit_value_o, 32'd0);
        rst_n = 1'b1;

        // Stream two characters with a ready consumer
        char_ready_i = 1'b1;
        bus_xfer("stdout_h", 1'b1, 5'h00, 32'h0000_0048, rd);
        bus_xfer("stdout_i", 1'b1, 5'h00, 32'hFFFF_FF69, rd);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stream_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() >= 2) begin
            check("stream_byte0", {24'd0, rx_q[0]}, 32'h48);
            check("stream_byte1", {24'd0, rx_q[1]}, 32'h69);
        end
        bus_xfer("stdout_read", 1'b0, 5'h00, 32'd0, rd);
        check("stdout_read_zero", rd, 32'd0);
        bus_xfer("unmapped_read", 1'b0, 5'h1C, 32'd0, rd);
        check("unmapped_read_zero", rd, 32'd0);

        // Fill the FIFO, then a 17th write waits until one pop
        char_ready_i = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 16; i++) bus_xfer("fill", 1'b1, 5'h00, 32'h30 + 32'(i), rd);
        bus_xfer("status_full", 1'b0, 5'h10, 32'd0, rd);
        check("status_full", rd, 32'h110);
        @(posedge clk); #1;
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = BASE; data_wdata_i = 32'h5A;
        @(negedge clk); check("full_gnt_a", {31'd0, data_gnt_o}, 32'd0);
        @(negedge clk); check("full_gnt_b", {31'd0, data_gnt_o}, 32'd0);
        @(posedge clk); #1; char_ready_i = 1'b1;
        @(negedge clk); check("full_gnt_c", {31'd0, data_gnt_o}, 32'd0);
        @(posedge clk); #1; char_ready_i = 1'b0;
        @(negedge clk); check("after_pop_gnt", {31'd0, data_gnt_o}, 32'd1);
        @(posedge clk); #1; data_req_i = 1'b0;
        @(negedge clk); check("after_pop_rvalid", {31'd0, data_rvalid_o}, 32'd1);
        check("popped_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() >= 1) check("popped_byte", {24'd0, rx_q[0]}, 32'h30);
        bus_xfer("status_refull", 1'b0, 5'h10, 32'd0, rd);
        check("status_refull", rd, 32'h110);
        char_ready_i = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("drain_count", 32'(rx_q.size()), 32'd17);
        if (rx_q.size() == 17) begin
            check("drain_byte15", {24'd0, rx_q[15]}, 32'h3F);
            check("drain_byte16", {24'd0, rx_q[16]}, 32'h5A);
        end

        // EXIT waits for three queued bytes to drain
        char_ready_i = 1'b0;
        rx_q.delete();
        bus_xfer("q_a", 1'b1, 5'h00, 32'h41, rd);
        bus_xfer("q_b", 1'b1, 5'h00, 32'h42, rd);
        bus_xfer("q_c", 1'b1, 5'h00, 32'h43, rd);
        @(posedge clk); #1;
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = BASE | 32'h4; data_wdata_i = 32'd0;
        @(negedge clk); check("exit_stall_a", {31'd0, data_gnt_o}, 32'd0);
        @(negedge clk); check("exit_stall_b", {31'd0, data_gnt_o}, 32'd0);
        @(posedge clk); #1; char_ready_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (data_gnt_o !== 1'b1 && n < 20);
        check("exit_wait_cycles", 32'(n), 32'd4);
        check("exit_valid_before", {31'd0, exit_valid_o}, 32'd0);
        @(posedge clk); #1; data_req_i = 1'b0;
        @(negedge clk);
        check("exit_rvalid", {31'd0, data_rvalid_o}, 32'd1);
        check("exit_valid_after", {31'd0, exit_valid_o}, 32'd1);
        check("exit_value_zero", exit_value_o, 32'd0);
        check("exit_drained", 32'(rx_q.size()), 32'd3);
        bus_xfer("exit_rewrite", 1'b1, 5'h04, 32'h0000_002A, rd);
        check("exit_value_rewrite", exit_value_o, 32'h2A);
        check("exit_valid_sticky", {31'd0, exit_valid_o}, 32'd1);

        // RESULT codes
        bus_xfer("res_5", 1'b1, 5'h08, 32'd5, rd);
        check("res_5_flags", {30'd0, tests_passed_o, tests_failed_o}, 32'd0);
        bus_xfer("res_pass", 1'b1, 5'h08, 32'd123456789, rd);
        check("res_pass_flags", {30'd0, tests_passed_o, tests_failed_o}, 32'd2);
        bus_xfer("res_fail", 1'b1, 5'h08, 32'd1, rd);
        check("res_fail_flags", {30'd0, tests_passed_o, tests_failed_o}, 32'd3);

        // Cycle counter: 10-cycle delta, then clear followed by an immediate read
        bus_xfer("cyc_a", 1'b0, 5'h0C, 32'd0, c0);
        repeat (8) @(posedge clk);
        bus_xfer("cyc_b", 1'b0, 5'h0C, 32'd0, c1);
        check("cycle_delta", c1 - c0, 32'd10);
        @(posedge clk); #1;
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = BASE | 32'hC; data_wdata_i = 32'hDEAD;
        @(negedge clk); check("cyc_clr_gnt", {31'd0, data_gnt_o}, 32'd1);
        @(posedge clk); #1;
        data_we_i = 1'b0;
        @(negedge clk); check("cyc_rd_gnt", {31'd0, data_gnt_o}, 32'd1);
        @(posedge clk); #1; data_req_i = 1'b0;
        @(negedge clk);
        check("cyc_rd_rvalid", {31'd0, data_rvalid_o}, 32'd1);
        check("cyc_after_clear", data_rdata_o, 32'd1);

        // Asynchronous reset mid-operation with bytes queued and a grant pending
        char_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) bus_xfer("pre_rst", 1'b1, 5'h00, 32'h60 + 32'(i), rd);
        @(posedge clk); #1;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = BASE | 32'h10;
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", {char_valid_o, tests_passed_o, tests_failed_o, exit_valid_o,
                             data_rvalid_o, 27'd0}, 32'd0);
        check("arst_exit_value", exit_value_o, 32'd0);
        check("arst_char_data", {24'd0, char_data_o}, 32'd0);
        data_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("arst_no_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_char_valid", {31'd0, char_valid_o}, 32'd0);
        bus_xfer("post_rst_status", 1'b0, 5'h10, 32'd0, rd);
        check("post_rst_status", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
